// File: rtl/mips_mem_pkg.sv
// Shared definitions for the unified-memory arbiter: access width encodings,
// read-owner state type, default bus widths and the alignment check.
package mips_mem_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b10;
    localparam logic [1:0] WIDTH_RSVD = 2'b11;

    // Who owns the read data returning from memory in the following cycle
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INSTR = 2'd1,
        DATA  = 2'd2,
        LOAD  = 2'd3
    } rd_owner_t;

    // Half needs addr[0]==0, word needs addr[1:0]==0, the reserved width always fails
    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] addr_lo);
        logic mis;
        case (width)
            WIDTH_HALF: mis = addr_lo[0];
            WIDTH_WORD: mis = (addr_lo != 2'b00);
            WIDTH_RSVD: mis = 1'b1;
            default:    mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of data grants won while fetch is waiting; force_i tells
// the arbiter to let fetch beat the data port once the run limit is reached.
module mem_arb_starve_ctr
    import mips_mem_pkg::*;
#(
    parameter int unsigned MAX_DATA_RUN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_req,
    input  logic i_gnt,
    input  logic d_gnt,
    output logic force_i
);

    localparam int unsigned      CNT_W   = $clog2(MAX_DATA_RUN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DATA_RUN);

    logic [CNT_W-1:0] r_cnt;

    // Count data wins against a pending fetch; a served or withdrawn fetch clears the run
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (!i_req || i_gnt) begin
            r_cnt <= '0;
        end else if (d_gnt && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign force_i = (r_cnt == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Unified single-port memory arbiter: loader > data > fetch, with fetch forced
// ahead of data after MAX_DATA_RUN consecutive data wins. Grant and memory
// command are combinational; read data is steered back one cycle later.
// Optional performance counters are built when MEM_ARB_PERF_EN is defined.
module mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned MAX_DATA_RUN = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    input  logic              d_req,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [1:0]        d_width,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_misalign,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    output logic              stall_if,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [1:0]        m_width,
    input  logic [DATA_W-1:0] m_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_i_gnt,
    output logic [31:0]       perf_d_gnt,
    output logic [31:0]       perf_if_stall,
    output logic [31:0]       perf_starve_force
`endif
);

    rd_owner_t         r_rd_owner;
    rd_owner_t         w_owner_nxt;
    logic [ADDR_W-1:0] r_m_addr;
    logic [DATA_W-1:0] r_m_wdata;
    logic              r_d_misalign;
    logic              w_force_i;
    logic              w_d_mis;
    logic              w_take_i;
    logic              w_take_d;

    mem_arb_starve_ctr #(
        .MAX_DATA_RUN (MAX_DATA_RUN)
    ) u_starve (
        .clk     (clk),
        .reset   (reset),
        .i_req   (i_req),
        .i_gnt   (i_gnt),
        .d_gnt   (d_gnt),
        .force_i (w_force_i)
    );

    // Read-owner register: remembers which port the returning read belongs to
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd_owner <= IDLE;
        end else begin
            r_rd_owner <= w_owner_nxt;
        end
    end

    // Priority select, owner next-state and memory command
    always_comb begin
        w_d_mis     = is_misaligned(d_width, d_addr[1:0]);
        w_take_i    = reset && !ld_req && i_req && (w_force_i || !d_req);
        w_take_d    = reset && !ld_req && d_req && !w_take_i;
        ld_gnt      = 1'b0;
        d_gnt       = 1'b0;
        i_gnt       = 1'b0;
        w_owner_nxt = IDLE;
        m_en        = 1'b0;
        m_we        = 1'b0;
        m_width     = WIDTH_BYTE;
        m_addr      = r_m_addr;
        m_wdata     = r_m_wdata;
        if (!reset) begin
            m_addr  = '0;
            m_wdata = '0;
        end else if (ld_req) begin
            ld_gnt      = 1'b1;
            w_owner_nxt = LOAD;
            m_en        = 1'b1;
            m_we        = 1'b1;
            m_addr      = ld_addr;
            m_wdata     = ld_wdata;
            m_width     = WIDTH_WORD;
        end else if (w_take_i) begin
            i_gnt       = 1'b1;
            w_owner_nxt = INSTR;
            m_en        = 1'b1;
            m_addr      = i_addr;
            m_width     = WIDTH_WORD;
        end else if (w_take_d) begin
            // A misaligned request is consumed but never reaches memory
            d_gnt = 1'b1;
            if (!w_d_mis) begin
                m_en    = 1'b1;
                m_we    = d_write;
                m_addr  = d_addr;
                m_width = d_width;
                if (d_write) begin
                    m_wdata = d_wdata;
                end else begin
                    w_owner_nxt = DATA;
                end
            end
        end
    end

    // Hold the last driven address/data through idle cycles; flag rejected data requests
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_m_addr     <= '0;
            r_m_wdata    <= '0;
            r_d_misalign <= 1'b0;
        end else begin
            r_m_addr     <= m_addr;
            r_m_wdata    <= m_wdata;
            r_d_misalign <= d_gnt && w_d_mis;
        end
    end

    assign stall_if   = i_req && !i_gnt;
    assign d_misalign = r_d_misalign;
    assign i_rvalid   = (r_rd_owner == INSTR);
    assign d_rvalid   = (r_rd_owner == DATA);
    assign i_rdata    = i_rvalid ? m_rdata : '0;
    assign d_rdata    = d_rvalid ? m_rdata : '0;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] r_perf_i_gnt;
    logic [31:0] r_perf_d_gnt;
    logic [31:0] r_perf_if_stall;
    logic [31:0] r_perf_starve_force;

    // Free-running event counters, wrapping modulo 2^32
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_perf_i_gnt        <= '0;
            r_perf_d_gnt        <= '0;
            r_perf_if_stall     <= '0;
            r_perf_starve_force <= '0;
        end else begin
            if (i_gnt)                       r_perf_i_gnt        <= r_perf_i_gnt + 32'd1;
            if (d_gnt)                       r_perf_d_gnt        <= r_perf_d_gnt + 32'd1;
            if (stall_if)                    r_perf_if_stall     <= r_perf_if_stall + 32'd1;
            if (i_gnt && w_force_i && d_req) r_perf_starve_force <= r_perf_starve_force + 32'd1;
        end
    end

    assign perf_i_gnt        = r_perf_i_gnt;
    assign perf_d_gnt        = r_perf_d_gnt;
    assign perf_if_stall     = r_perf_if_stall;
    assign perf_starve_force = r_perf_starve_force;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, contention, starvation, loader,
// misalignment and reset-during-read sequences with hand-computed expectations.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_req, ld_gnt;
  logic [31:0] ld_addr, ld_wdata;
  logic        d_req, d_write, d_gnt, d_rvalid, d_misalign;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [1:0]  d_width;
  logic        i_req, i_gnt, i_rvalid, stall_if;
  logic [31:0] i_addr, i_rdata;
  logic        m_en, m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [1:0]  m_width;

  int n_vec = 0;
  int n_err = 0;
  logic [9:0] exp_i_pat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  mem_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .MAX_DATA_RUN (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ld_req     (ld_req),
    .ld_addr    (ld_addr),
    .ld_wdata   (ld_wdata),
    .ld_gnt     (ld_gnt),
    .d_req      (d_req),
    .d_write    (d_write),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_width    (d_width),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .d_misalign (d_misalign),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_gnt      (i_gnt),
    .i_rvalid   (i_rvalid),
    .i_rdata    (i_rdata),
    .stall_if   (stall_if),
    .m_en       (m_en),
    .m_we       (m_we),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_width    (m_width),
    .m_rdata    (m_rdata)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge; checks follow 1ns later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic no_req();
    ld_req = 1'b0;
    d_req  = 1'b0;
    i_req  = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    ld_req = 1'b1; ld_addr = 32'h0; ld_wdata = 32'h0;
    d_req = 1'b1; d_write = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_width = 2'b10;
    i_req = 1'b1; i_addr = 32'h0;
    m_rdata = 32'h0;

    // Reset held with every request active
    for (int unsigned c = 0; c < 3; c++) begin
      step(); #1;
      chk("rst_ld_gnt", ld_gnt, 1'b0);
      chk("rst_d_gnt", d_gnt, 1'b0);
      chk("rst_i_gnt", i_gnt, 1'b0);
      chk("rst_m_en", m_en, 1'b0);
      chk("rst_i_rvalid", i_rvalid, 1'b0);
      chk("rst_d_rvalid", d_rvalid, 1'b0);
    end
    reset = 1'b1;
    no_req();
    step(); #1;
    chk("idle_m_en", m_en, 1'b0);
    chk("idle_m_addr", m_addr, 32'h0);
    chk("idle_i_rdata", i_rdata, 32'h0);
    chk("idle_d_rdata", d_rdata, 32'h0);
    chk("idle_d_misalign", d_misalign, 1'b0);
    chk("idle_stall_if", stall_if, 1'b0);

    // Contention: data load wins, fetch stalls then goes next
    step();
    i_req = 1'b1; i_addr = 32'h40;
    d_req = 1'b1; d_write = 1'b0; d_addr = 32'h100; d_width = 2'b10;
    #1;
    chk("cont_d_gnt", d_gnt, 1'b1);
    chk("cont_i_gnt", i_gnt, 1'b0);
    chk("cont_stall", stall_if, 1'b1);
    chk("cont_m_en", m_en, 1'b1);
    chk("cont_m_we", m_we, 1'b0);
    chk("cont_m_addr", m_addr, 32'h100);
    chk("cont_m_width", m_width, 2'b10);
    step();
    d_req = 1'b0; m_rdata = 32'hDEADBEEF;
    #1;
    chk("cont_d_rvalid", d_rvalid, 1'b1);
    chk("cont_d_rdata", d_rdata, 32'hDEADBEEF);
    chk("cont_i_rvalid_early", i_rvalid, 1'b0);
    chk("cont_i_gnt_n1", i_gnt, 1'b1);
    chk("cont_m_addr_i", m_addr, 32'h40);
    chk("cont_stall_n1", stall_if, 1'b0);
    step();
    i_req = 1'b0; m_rdata = 32'h12345678;
    #1;
    chk("cont_i_rvalid", i_rvalid, 1'b1);
    chk("cont_i_rdata", i_rdata, 32'h12345678);
    chk("cont_d_rvalid_n2", d_rvalid, 1'b0);
    chk("cont_idle_m_en", m_en, 1'b0);
    chk("cont_hold_m_addr", m_addr, 32'h40);

    // Starvation: stores held 10 cycles with fetch pending; fetch forced in at 4 and 9
    exp_i_pat = 10'b10_0001_0000;
    for (int unsigned k = 0; k < 10; k++) begin
      step();
      i_req = 1'b1; i_addr = 32'h80;
      d_req = 1'b1; d_write = 1'b1; d_addr = 32'h200; d_width = 2'b10; d_wdata = 32'hA5A55A5A;
      m_rdata = 32'h0;
      #1;
      chk("starve_i_gnt", i_gnt, exp_i_pat[k]);
      chk("starve_d_gnt", d_gnt, !exp_i_pat[k]);
      chk("starve_m_we", m_we, !exp_i_pat[k]);
      chk("starve_i_rvalid", i_rvalid, (k == 5));
      chk("starve_d_rvalid", d_rvalid, 1'b0);
    end
    step();
    no_req();
    #1;
    chk("starve_last_i_rvalid", i_rvalid, 1'b1);
    chk("starve_hold_m_addr", m_addr, 32'h80);
    chk("starve_hold_m_wdata", m_wdata, 32'hA5A55A5A);

    // Loader beats everything; no read data comes back for its writes
    for (int unsigned c = 0; c < 2; c++) begin
      step();
      ld_req = 1'b1; ld_addr = 32'h300; ld_wdata = 32'hCAFEF00D;
      d_req = 1'b1; d_write = 1'b0; d_addr = 32'h104; d_width = 2'b10;
      i_req = 1'b1; i_addr = 32'hC0;
      #1;
      chk("ld_ld_gnt", ld_gnt, 1'b1);
      chk("ld_d_gnt", d_gnt, 1'b0);
      chk("ld_i_gnt", i_gnt, 1'b0);
      chk("ld_m_we", m_we, 1'b1);
      chk("ld_m_addr", m_addr, 32'h300);
      chk("ld_m_wdata", m_wdata, 32'hCAFEF00D);
      chk("ld_m_width", m_width, 2'b10);
      chk("ld_stall", stall_if, 1'b1);
      chk("ld_i_rvalid", i_rvalid, 1'b0);
      chk("ld_d_rvalid", d_rvalid, 1'b0);
    end
    step();
    ld_req = 1'b0;
    #1;
    chk("ld_after_d_gnt", d_gnt, 1'b1);
    chk("ld_after_i_gnt", i_gnt, 1'b0);
    chk("ld_after_m_addr", m_addr, 32'h104);
    chk("ld_after_m_we", m_we, 1'b0);
    chk("ld_after_d_rvalid", d_rvalid, 1'b0);
    step();
    d_req = 1'b0; m_rdata = 32'h0BADF00D;
    #1;
    chk("ld_after_d_rdata", d_rdata, 32'h0BADF00D);
    chk("ld_after_i_gnt2", i_gnt, 1'b1);
    chk("ld_after_m_addr_i", m_addr, 32'hC0);
    step();
    i_req = 1'b0; m_rdata = 32'h11112222;
    #1;
    chk("ld_after_i_rdata", i_rdata, 32'h11112222);

    // Misalignment: request consumed, memory untouched, flag one cycle later
    step();
    d_req = 1'b1; d_write = 1'b0; d_width = 2'b10; d_addr = 32'h102;
    i_req = 1'b1; i_addr = 32'hC4; m_rdata = 32'h0;
    #1;
    chk("mis_w_d_gnt", d_gnt, 1'b1);
    chk("mis_w_m_en", m_en, 1'b0);
    chk("mis_w_i_gnt", i_gnt, 1'b0);
    chk("mis_w_stall", stall_if, 1'b1);
    chk("mis_w_flag_early", d_misalign, 1'b0);
    chk("mis_w_hold_m_addr", m_addr, 32'hC0);
    step();
    i_req = 1'b0; d_width = 2'b01; d_addr = 32'h101;
    #1;
    chk("mis_w_flag", d_misalign, 1'b1);
    chk("mis_w_d_rvalid", d_rvalid, 1'b0);
    chk("mis_h_m_en", m_en, 1'b0);
    step();
    d_width = 2'b11; d_addr = 32'h100;
    #1;
    chk("mis_h_flag", d_misalign, 1'b1);
    chk("mis_r_m_en", m_en, 1'b0);
    step();
    d_width = 2'b01; d_addr = 32'h102;
    #1;
    chk("mis_r_flag", d_misalign, 1'b1);
    chk("half_ok_m_en", m_en, 1'b1);
    chk("half_ok_m_width", m_width, 2'b01);
    chk("half_ok_m_addr", m_addr, 32'h102);
    step();
    d_req = 1'b0; m_rdata = 32'h0000BEEF;
    #1;
    chk("half_ok_flag", d_misalign, 1'b0);
    chk("half_ok_d_rdata", d_rdata, 32'h0000BEEF);

    // Reset arriving right after a fetch grant suppresses its read data
    step();
    i_req = 1'b1; i_addr = 32'h10; m_rdata = 32'h0;
    #1;
    chk("rr_i_gnt", i_gnt, 1'b1);
    chk("rr_m_addr", m_addr, 32'h10);
    reset = 1'b0;
    step();
    m_rdata = 32'h55;
    #1;
    chk("rr_i_rvalid", i_rvalid, 1'b0);
    chk("rr_i_rdata", i_rdata, 32'h0);
    chk("rr_i_gnt_rst", i_gnt, 1'b0);
    chk("rr_stall", stall_if, 1'b1);
    chk("rr_m_addr_rst", m_addr, 32'h0);
    reset = 1'b1;
    no_req();
    step(); #1;
    chk("rr_post_m_addr", m_addr, 32'h0);
    chk("rr_post_i_rvalid", i_rvalid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
